// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants, also used by the core top for the boot PC.
package if_pkg;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      WAIT_ACK = 2'd1,
      HOLD     = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC   = 32'h8000_0000;

   // Wide enough for bus widths up to 512 bits; users slice what they need.
   localparam logic [63:0] WB_SEL_ALL = '1;

endpackage

// File: rtl/wb_read_master.sv
// Single-beat Wishbone classic read master: cyc/stb registered one cycle after req, held until ack.
// Latency = wait states + 1 after launch; abort never cuts a bus cycle, it only marks the result as dropped.
module wb_read_master #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RST_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  abort,
   output logic                  done,
   output logic                  drop,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   input  logic                  wb_ack_i
);

   logic discard;

   // An ack with no cycle open (e.g. straggling across a reset) is never seen as done.
   assign done = wb_cyc_o & wb_ack_i;
   assign drop = discard | abort;
   assign data = wb_dat_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_adr_o <= RST_ADDR;
         discard  <= 1'b0;
      end else begin
         if (!wb_cyc_o) begin
            if (req) begin
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               wb_adr_o <= addr;
            end
         end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
         end

         if (done)
            discard <= 1'b0;
         else if (wb_cyc_o && abort)
            discard <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: one Wishbone read per PC, result held for decode until accepted; 3 cycles minimum per fetch.
// Decode backpressure holds the stage in HOLD with pc/inst stable; redirect overrides accept.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(RESET_PC)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   pc_next_in,
   input  logic                    redirect,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   output logic                    inst_valid,
   input  logic                    inst_ready,
   output logic [DATA_WIDTH-1:0]   inst_out,
   output logic [ADDR_WIDTH-1:0]   pc_out
);

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] RST_PC     = PC_ADDR & ALIGN_MASK;

   fetch_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_reg;
   logic [ADDR_WIDTH-1:0]   pc_load_val;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    req, done, drop;
   logic                    load_pc, capture, set_valid, clr_valid;

   assign wb_we_o  = 1'b0;
   assign wb_sel_o = WB_SEL_ALL[DATA_WIDTH/8-1:0];

   wb_read_master #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .RST_ADDR   (RST_PC)
   ) u_wb (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .addr     (pc_reg),
      .abort    (redirect),
      .done     (done),
      .drop     (drop),
      .data     (rd_data),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= FETCH;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req         = 1'b0;
      load_pc     = 1'b0;
      pc_load_val = pc_next_in;
      capture     = 1'b0;
      set_valid   = 1'b0;
      clr_valid   = 1'b0;
      case (state_q)
         FETCH: begin
            if (redirect) begin
               load_pc     = 1'b1;
               pc_load_val = redirect_pc;
               clr_valid   = 1'b1;
            end else begin
               req     = 1'b1;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // The bus cycle runs to completion; a redirect only retargets the next fetch.
            if (redirect) begin
               load_pc     = 1'b1;
               pc_load_val = redirect_pc;
            end
            if (done) begin
               capture = 1'b1;
               if (drop) begin
                  state_d = FETCH;
               end else begin
                  set_valid = 1'b1;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               load_pc     = 1'b1;
               pc_load_val = redirect_pc;
               clr_valid   = 1'b1;
               state_d     = FETCH;
            end else if (inst_ready) begin
               load_pc   = 1'b1;
               clr_valid = 1'b1;
               state_d   = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg     <= RST_PC;
         inst_valid <= 1'b0;
         inst_out   <= '0;
         pc_out     <= RST_PC;
      end else begin
         if (load_pc)
            pc_reg <= pc_load_val & ALIGN_MASK;
         if (capture) begin
            inst_out <= rd_data;
            pc_out   <= pc_reg;
         end
         if (set_valid)
            inst_valid <= 1'b1;
         else if (clr_valid)
            inst_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table for streaming/hold/redirect, hand sequences for bus corner cases.
module tb_if_fetch_stage;

   localparam logic [31:0] A = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_next_in, redirect_pc;
   logic        redirect, inst_ready;
   logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic [31:0] wb_adr_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        inst_valid;
   logic [31:0] inst_out, pc_out;

   int          wait_states;
   logic        late_ack;
   logic [3:0]  ws_cnt;
   int          passed = 0;
   int          total = 0;

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] pnext;
      logic        e_cyc;
      logic [31:0] e_adr;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t vecs[$];

   if_fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .pc_next_in  (pc_next_in),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_adr_o    (wb_adr_o),
      .wb_sel_o    (wb_sel_o),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_i    (wb_ack_i),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .pc_out      (pc_out)
   );

   always #5 clk = ~clk;

   // Memory image: word at address a holds (a[15:0] << 12) | 0x13.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a & 32'h0000_FFFF) << 12) | 32'h0000_0013;
   endfunction

   assign wb_dat_i = mem_word(wb_adr_o);
   assign wb_ack_i = late_ack | (wb_cyc_o && wb_stb_o && (int'(ws_cnt) == wait_states));

   always @(posedge clk or posedge reset) begin
      if (reset)
         ws_cnt <= '0;
      else if (wb_cyc_o && wb_stb_o && !wb_ack_i)
         ws_cnt <= ws_cnt + 4'd1;
      else
         ws_cnt <= '0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      else
         passed++;
   endtask

   function automatic vec_t mk(input logic ready, input logic redir, input logic [31:0] rpc,
                               input logic [31:0] pnext, input logic e_cyc, input logic [31:0] e_adr,
                               input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_inst);
      vec_t v;
      v.ready = ready;  v.redir = redir;  v.rpc = rpc;  v.pnext = pnext;
      v.e_cyc = e_cyc;  v.e_adr = e_adr;  v.e_vld = e_vld;
      v.e_pc  = e_pc;   v.e_inst = e_inst;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      pc_next_in  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
      late_ack    = 1'b0;
      wait_states = 0;

      // ---- reset state and first fetch with a zero-wait slave ----
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst_out, 32'd0);
      chk("rst_pc_out", pc_out, A);
      chk("we_const", 32'(wb_we_o), 32'd0);
      chk("sel_const", 32'(wb_sel_o), 32'hF);
      reset = 1'b0;
      step();
      chk("first_cyc", 32'(wb_cyc_o), 32'd1);
      chk("first_adr", wb_adr_o, A);
      chk("first_valid_early", 32'(inst_valid), 32'd0);
      step();
      chk("first_valid", 32'(inst_valid), 32'd1);
      chk("first_inst", inst_out, 32'h0000_0013);
      chk("first_pc", pc_out, A);

      // ---- table: streaming, 5-cycle hold, alignment, redirect vs accept, redirect in FETCH ----
      vecs.push_back(mk(1, 0, 0, A + 4,            0, 0,          0, 0,          0));
      vecs.push_back(mk(1, 0, 0, A + 4,            1, A + 4,      0, 0,          0));
      vecs.push_back(mk(1, 0, 0, A + 4,            0, 0,          1, A + 4,      32'h0000_4013));
      vecs.push_back(mk(1, 0, 0, A + 8,            0, 0,          0, 0,          0));
      vecs.push_back(mk(1, 0, 0, A + 8,            1, A + 8,      0, 0,          0));
      vecs.push_back(mk(0, 0, 0, A + 8,            0, 0,          1, A + 8,      32'h0000_8013));
      vecs.push_back(mk(0, 0, 0, 32'h1111_1110,    0, 0,          1, A + 8,      32'h0000_8013));
      vecs.push_back(mk(0, 0, 0, 32'h2222_2220,    0, 0,          1, A + 8,      32'h0000_8013));
      vecs.push_back(mk(0, 0, 0, 32'h3333_3330,    0, 0,          1, A + 8,      32'h0000_8013));
      vecs.push_back(mk(0, 0, 0, 32'h4444_4440,    0, 0,          1, A + 8,      32'h0000_8013));
      vecs.push_back(mk(0, 0, 0, 32'h5555_5550,    0, 0,          1, A + 8,      32'h0000_8013));
      vecs.push_back(mk(1, 0, 0, A + 32'h20,       0, 0,          0, 0,          0));
      vecs.push_back(mk(0, 0, 0, 32'h6666_6660,    1, A + 32'h20, 0, 0,          0));
      vecs.push_back(mk(0, 0, 0, 32'h6666_6660,    0, 0,          1, A + 32'h20, 32'h0002_0013));
      vecs.push_back(mk(1, 0, 0, A + 32'h33,       0, 0,          0, 0,          0));
      vecs.push_back(mk(0, 0, 0, A + 32'h33,       1, A + 32'h30, 0, 0,          0));
      vecs.push_back(mk(0, 0, 0, A + 32'h33,       0, 0,          1, A + 32'h30, 32'h0003_0013));
      vecs.push_back(mk(1, 1, A + 32'h200, A + 32'h40, 0, 0,      0, 0,          0));
      vecs.push_back(mk(0, 0, 0, A + 32'h40,       1, A + 32'h200, 0, 0,         0));
      vecs.push_back(mk(0, 0, 0, A + 32'h40,       0, 0,          1, A + 32'h200, 32'h0020_0013));
      vecs.push_back(mk(1, 0, 0, A + 32'h204,      0, 0,          0, 0,          0));
      vecs.push_back(mk(0, 1, A + 32'h300, A + 32'h204, 0, 0,     0, 0,          0));
      vecs.push_back(mk(0, 0, 0, A + 32'h204,      1, A + 32'h300, 0, 0,         0));
      vecs.push_back(mk(0, 0, 0, A + 32'h204,      0, 0,          1, A + 32'h300, 32'h0030_0013));

      foreach (vecs[i]) begin
         inst_ready  = vecs[i].ready;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         pc_next_in  = vecs[i].pnext;
         step();
         chk($sformatf("vec%0d_cyc", i), 32'(wb_cyc_o), 32'(vecs[i].e_cyc));
         chk($sformatf("vec%0d_stb", i), 32'(wb_stb_o), 32'(vecs[i].e_cyc));
         if (vecs[i].e_cyc)
            chk($sformatf("vec%0d_adr", i), wb_adr_o, vecs[i].e_adr);
         chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].e_vld));
         if (vecs[i].e_vld) begin
            chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].e_pc);
            chk($sformatf("vec%0d_inst", i), inst_out, vecs[i].e_inst);
         end
      end
      redirect = 1'b0;

      // ---- 4 wait states, redirect in the 2nd wait cycle: cycle completes, data dropped ----
      wait_states = 4;
      inst_ready  = 1'b1;
      pc_next_in  = A + 32'h304;
      step();
      inst_ready = 1'b0;
      step();
      chk("ws_cyc", 32'(wb_cyc_o), 32'd1);
      chk("ws_adr", wb_adr_o, A + 32'h304);
      step();
      redirect    = 1'b1;
      redirect_pc = A + 32'h100;
      step();
      redirect = 1'b0;
      chk("ws_cyc_held", 32'(wb_cyc_o), 32'd1);
      chk("ws_adr_held", wb_adr_o, A + 32'h304);
      n = 0;
      while (wb_cyc_o && n < 20) begin
         chk("ws_no_valid", 32'(inst_valid), 32'd0);
         step();
         n++;
      end
      chk("ws_cycles_to_ack", n, 3);
      chk("ws_discarded", 32'(inst_valid), 32'd0);
      step();
      chk("ws_refetch_cyc", 32'(wb_cyc_o), 32'd1);
      chk("ws_refetch_adr", wb_adr_o, A + 32'h100);
      n = 0;
      while (!inst_valid && n < 20) begin
         step();
         n++;
      end
      chk("ws_refetch_valid", 32'(inst_valid), 32'd1);
      chk("ws_refetch_pc", pc_out, A + 32'h100);
      chk("ws_refetch_inst", inst_out, 32'h0010_0013);

      // ---- redirect coinciding with ack: data dropped, refetch at redirect target ----
      wait_states = 0;
      inst_ready  = 1'b1;
      pc_next_in  = A + 32'h104;
      step();
      inst_ready = 1'b0;
      step();
      chk("ackred_adr", wb_adr_o, A + 32'h104);
      redirect    = 1'b1;
      redirect_pc = A + 32'h400;
      step();
      redirect = 1'b0;
      chk("ackred_valid", 32'(inst_valid), 32'd0);
      chk("ackred_cyc", 32'(wb_cyc_o), 32'd0);
      step();
      chk("ackred_refetch_adr", wb_adr_o, A + 32'h400);
      step();
      chk("ackred_valid2", 32'(inst_valid), 32'd1);
      chk("ackred_pc", pc_out, A + 32'h400);
      chk("ackred_inst", inst_out, 32'h0040_0013);

      // ---- reset during WAIT_ACK, then a stale ack after release ----
      wait_states = 4;
      inst_ready  = 1'b1;
      pc_next_in  = A + 32'h404;
      step();
      inst_ready = 1'b0;
      step();
      chk("rstmid_cyc_before", 32'(wb_cyc_o), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstmid_cyc_async", 32'(wb_cyc_o), 32'd0);
      chk("rstmid_stb_async", 32'(wb_stb_o), 32'd0);
      chk("rstmid_valid", 32'(inst_valid), 32'd0);
      step();
      wait_states = 0;
      reset       = 1'b0;
      late_ack    = 1'b1;
      step();
      late_ack = 1'b0;
      chk("stale_ack_valid", 32'(inst_valid), 32'd0);
      chk("restart_cyc", 32'(wb_cyc_o), 32'd1);
      chk("restart_adr", wb_adr_o, A);
      step();
      chk("restart_valid", 32'(inst_valid), 32'd1);
      chk("restart_pc", pc_out, A);
      chk("restart_inst", inst_out, 32'h0000_0013);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the SUM next-PC adder.
- Holds the architectural PC register and fetches one 32-bit instruction per PC over a Wishbone classic read-only master port.
- Presents {PC, instruction} to decode through a valid/ready handshake.
- On each accepted instruction, loads the next PC that SUM computes (PC+4 or PC+imm) from the presented PC. Redirect (trap/flush) overrides.

Parameters:
- PC_ADDR, 32'h8000_0000, PC value loaded on reset.
- ADDR_WIDTH, 32, PC and bus address width.
- DATA_WIDTH, 32, instruction and bus data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_next_in  in  ADDR_WIDTH  next PC from SUM (PC_reg_out of SUM).
- redirect  in  1  flush request; higher priority than pc_next_in.
- redirect_pc  in  ADDR_WIDTH  PC to fetch after a redirect.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  always 0.
- wb_adr_o  out  ADDR_WIDTH  fetch address, equal to pc_reg.
- wb_sel_o  out  DATA_WIDTH/8  all ones.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- inst_valid  out  1  inst_out/pc_out are valid.
- inst_ready  in  1  decode accepts this cycle.
- inst_out  out  DATA_WIDTH  fetched instruction.
- pc_out  out  ADDR_WIDTH  PC of inst_out; feeds SUM PC_reg_in.

Behaviour:
- Reset (async assert, sync release): pc_reg=PC_ADDR, state=FETCH, wb_cyc_o=wb_stb_o=0, inst_valid=0, inst_out=0, pc_out=PC_ADDR, discard flag=0.
- FSM states: FETCH, WAIT_ACK, HOLD.
- FETCH:
  - Drive wb_cyc_o=wb_stb_o=1 and wb_adr_o=pc_reg (registered outputs, asserted the cycle after entry).
  - Next state is WAIT_ACK.
- WAIT_ACK:
  - Keep cyc/stb/adr stable until wb_ack_i.
  - On ack: deassert cyc/stb in the same edge and capture inst_out<=wb_dat_i, pc_out<=pc_reg.
  - If discard=0: inst_valid<=1, go to HOLD.
  - If discard=1: clear discard, drop the data (inst_valid stays 0), go to FETCH.
- HOLD:
  - inst_valid=1; inst_out and pc_out are stable while inst_ready=0.
  - On inst_valid&&inst_ready: pc_reg<=pc_next_in, inst_valid<=0, go to FETCH.
- Minimum latency is 3 cycles from FETCH entry to inst_valid with a zero-wait slave (ack on the first stb cycle). One instruction is in flight at a time; no prefetch.
- Redirect, which has priority over accept in the same cycle:
  - In FETCH or HOLD: pc_reg<=redirect_pc, inst_valid<=0, go to FETCH. Any accept in that same cycle is ignored.
  - In WAIT_ACK without ack: do not abort the bus cycle. Set pc_reg<=redirect_pc and discard<=1. Completion then follows the WAIT_ACK rule above.
  - In WAIT_ACK with ack in the same cycle: drop the data, pc_reg<=redirect_pc, go to FETCH.
  - Repeated redirects while discard=1 overwrite pc_reg; the last one wins.
- Alignment: pc_reg[1:0] is forced to 2'b00 on every load (reset, accept, redirect).
- Width: pc_next_in and redirect_pc are used as-is (no sign/zero extension); wrap-around at 2^ADDR_WIDTH is natural.
- Reset asserted mid-bus-cycle: cyc/stb drop immediately. A late wb_ack_i after reset is ignored because the FSM is in FETCH.
- wb_ack_i outside WAIT_ACK is ignored.

Decomposition:
- Package if_pkg:
  - fetch_state_e enum {FETCH, WAIT_ACK, HOLD}.
  - WB_SEL_ALL constant.
  - Reset PC default constant, shared with the core top.
- Sub-module wb_read_master: owns cyc/stb/adr/ack handling and the discard flag. Interface is req/addr in, done/data out, plus abort-ignore.
- Top if_fetch_stage: owns the PC register, the FSM and the output handshake.

Test Plan:
- Reset with zero-wait slave returning 32'h0000_0013 at 0x8000_0000 → wb_adr_o=0x8000_0000; inst_valid=1, inst_out=0x13, pc_out=0x8000_0000 on the 3rd cycle after reset release.
- inst_ready=1 every cycle, pc_next_in=pc_out+4, ack on the first stb cycle → fetches 0x8000_0000, 0x8000_0004, 0x8000_0008 in order, each valid for exactly 1 cycle.
- inst_ready held 0 for 5 cycles in HOLD, pc_next_in changing → inst_out/pc_out stable, no new bus cycle. Accept loads the pc_next_in value seen on the accept cycle.
- Slave with 4 wait states, redirect=1 with redirect_pc=0x8000_0100 in the 2nd wait cycle → cyc held until ack, data discarded (inst_valid stays 0), next wb_adr_o=0x8000_0100.
- Redirect and inst_ready both 1 in HOLD with pc_next_in=0x8000_0040, redirect_pc=0x8000_0200 → next fetch address is 0x8000_0200.
- Reset asserted during WAIT_ACK, then a late ack → cyc/stb=0 asynchronously; after release the fetch restarts at 0x8000_0000 and the stale ack produces no inst_valid.
